alu_arbiter: RTL and testbench

Shares the single combinational 32-bit ALU between two requesters: port 0, the main pipeline's execute stage, and port 1, the auxiliary multi-cycle unit (mult/div, debug). Each operation is accepted with a valid/ready handshake and its operands are registered. The operands then drive the ALU for one cycle. The result, overflow and disable flags are captured and held until the owning requester takes them. The block sits between the requesters and the ALU instance; the ALU itself is unchanged and stays external.

---
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational 32-bit ALU.
// One operation in flight at a time: accept, execute for one cycle, hold the result until taken.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [3:0]  req_op0,
    input  logic [3:0]  req_op1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_c,
    output logic        rsp_ovf,
    output logic        rsp_dis,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_c,
    input  logic        alu_ovf,
    input  logic        alu_dis
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        owner;
    logic        last_grant;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_code;
    logic        grant;
    logic        accept;
    logic        ovf_defined;

    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = RR_EN ? ~last_grant : 1'b0;
            default: grant = 1'b0;
        endcase
    end

    assign accept = (state == IDLE) && (req_valid != 2'b00);

    // Gated by rst_n so a requester holding valid through reset never sees a ready.
    assign req_ready = (accept && rst_n) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    // ALU overflow is only meaningful for the two signed arithmetic opcodes.
    assign ovf_defined = (op_code == 4'b0100) || (op_code == 4'b1001);

    assign alu_a  = op_a;
    assign alu_b  = op_b;
    assign alu_op = op_code;

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= 4'b0000;
            rsp_c      <= '0;
            rsp_ovf    <= 1'b0;
            rsp_dis    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant;
                        last_grant <= grant;
                        op_a       <= grant ? req_a1  : req_a0;
                        op_b       <= grant ? req_b1  : req_b0;
                        op_code    <= grant ? req_op1 : req_op0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_c   <= alu_c;
                    rsp_dis <= alu_dis;
                    rsp_ovf <= ovf_defined & alu_ovf;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share one stimulus
// stream; a transaction-level model predicts both, plus hand-computed literal checks.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;

    logic [1:0]  rr_req_ready, rr_rsp_valid, fp_req_ready, fp_rsp_valid;
    logic [31:0] rr_rsp_c, rr_alu_a, rr_alu_b, fp_rsp_c, fp_alu_a, fp_alu_b;
    logic [3:0]  rr_alu_op, fp_alu_op;
    logic        rr_rsp_ovf, rr_rsp_dis, fp_rsp_ovf, fp_rsp_dis;
    logic [33:0] rr_alu_res, fp_alu_res;

    int n_cmp  = 0;
    int n_fail = 0;

    // External ALU stand-in: {dis, ovf, c}. Overflow is always computed from the
    // add/sub so that it is non-zero garbage for opcodes where it must be masked.
    function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [31:0] s, d, c;
        logic        ovf, dis;
        s   = a + b;
        d   = a - b;
        dis = 1'b0;
        case (op)
            4'b0000, 4'b1001: c = s;
            4'b0100:          c = d;
            4'b1011: begin c = a; dis = 1'b1; end
            default:          c = a ^ b;
        endcase
        if (op == 4'b0100) ovf = (a[31] != b[31]) && (d[31] != a[31]);
        else               ovf = (a[31] == b[31]) && (s[31] != a[31]);
        return {dis, ovf, c};
    endfunction

    assign rr_alu_res = alu_ref(rr_alu_a, rr_alu_b, rr_alu_op);
    assign fp_alu_res = alu_ref(fp_alu_a, fp_alu_b, fp_alu_op);

    alu_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(rr_req_ready),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .req_op0(op0), .req_op1(op1),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rr_rsp_c), .rsp_ovf(rr_rsp_ovf), .rsp_dis(rr_rsp_dis),
        .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op),
        .alu_c(rr_alu_res[31:0]), .alu_ovf(rr_alu_res[32]), .alu_dis(rr_alu_res[33])
    );

    alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(fp_req_ready),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .req_op0(op0), .req_op1(op1),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(fp_rsp_c), .rsp_ovf(fp_rsp_ovf), .rsp_dis(fp_rsp_dis),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op),
        .alu_c(fp_alu_res[31:0]), .alu_ovf(fp_alu_res[32]), .alu_dis(fp_alu_res[33])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction model, one slot per instance (0 = round-robin, 1 = fixed priority).
    bit          m_busy [2];
    int          m_age  [2];
    bit          m_owner[2];
    bit          m_last [2];
    logic [31:0] m_a[2], m_b[2], m_c[2];
    logic [3:0]  m_op[2];
    logic        m_ovf[2], m_dis[2];
    bit          glog[2][8];
    int          glog_n[2];

    function automatic logic [1:0] pick(input logic [1:0] v, input bit last, input bit rr);
        if (v == 2'b01) return 2'b01;
        if (v == 2'b10) return 2'b10;
        if (v == 2'b11) return rr ? (last ? 2'b01 : 2'b10) : 2'b01;
        return 2'b00;
    endfunction

    task automatic model_step(input int i, input logic [1:0] rdy, input logic [1:0] vld,
                              input logic [31:0] c, input logic ovf, input logic dis,
                              input logic [31:0] aa, input logic [31:0] bb, input logic [3:0] oo);
        logic [1:0]  g, e_rdy, e_vld;
        logic [33:0] r;
        string       p;
        p = (i == 0) ? "rr" : "fp";
        g = 2'b00;
        if (!rst_n) begin
            m_busy[i] = 0; m_age[i] = 0; m_owner[i] = 0; m_last[i] = 1;
            m_a[i] = '0; m_b[i] = '0; m_op[i] = '0;
            m_c[i] = '0; m_ovf[i] = 0; m_dis[i] = 0;
            glog_n[i] = 0;
            e_rdy = 2'b00;
            e_vld = 2'b00;
        end else begin
            g     = pick(req_valid, m_last[i], i == 0);
            e_rdy = m_busy[i] ? 2'b00 : g;
            e_vld = (m_busy[i] && m_age[i] >= 1) ? (m_owner[i] ? 2'b10 : 2'b01) : 2'b00;
        end
        check({p, ".req_ready"}, 32'(rdy), 32'(e_rdy));
        check({p, ".rsp_valid"}, 32'(vld), 32'(e_vld));
        check({p, ".rsp_c"},     c,        m_c[i]);
        check({p, ".rsp_ovf"},   32'(ovf), 32'(m_ovf[i]));
        check({p, ".rsp_dis"},   32'(dis), 32'(m_dis[i]));
        check({p, ".alu_a"},     aa,       m_a[i]);
        check({p, ".alu_b"},     bb,       m_b[i]);
        check({p, ".alu_op"},    32'(oo),  32'(m_op[i]));
        if (rst_n) begin
            if (((rdy & req_valid) != 2'b00) && glog_n[i] < 8) begin
                glog[i][glog_n[i]] = rdy[1];
                glog_n[i]++;
            end
            if (!m_busy[i]) begin
                if (g != 2'b00) begin
                    m_busy[i] = 1; m_age[i] = 0;
                    m_owner[i] = g[1]; m_last[i] = g[1];
                    m_a[i]  = g[1] ? a1  : a0;
                    m_b[i]  = g[1] ? b1  : b0;
                    m_op[i] = g[1] ? op1 : op0;
                end
            end else if (m_age[i] == 0) begin
                r = alu_ref(m_a[i], m_b[i], m_op[i]);
                m_c[i]   = r[31:0];
                m_dis[i] = r[33];
                m_ovf[i] = (m_op[i] == 4'b0100 || m_op[i] == 4'b1001) ? r[32] : 1'b0;
                m_age[i] = 1;
            end else if ((rsp_ready & e_vld) != 2'b00) begin
                m_busy[i] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, rr_req_ready, rr_rsp_valid, rr_rsp_c, rr_rsp_ovf, rr_rsp_dis,
                   rr_alu_a, rr_alu_b, rr_alu_op);
        model_step(1, fp_req_ready, fp_rsp_valid, fp_rsp_c, fp_rsp_ovf, fp_rsp_dis,
                   fp_alu_a, fp_alu_b, fp_alu_op);
    end

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting, expected event within budget", name);
    endtask

    // Issues one request on a port and waits for its response; returns at the
    // negedge of the first response cycle with the cycle counts to ready and to rsp_valid.
    task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, output int lat_rdy, output int lat_rsp);
        bit ok;
        @(posedge clk); #1;
        if (port == 0) begin a0 = a; b0 = b; op0 = op; end
        else           begin a1 = a; b1 = b; op1 = op; end
        req_valid[port] = 1'b1;
        ok = 0;
        lat_rdy = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            lat_rdy++;
            if (rr_req_ready[port]) ok = 1;
        end
        if (!ok) timeout_fail("req_ready wait");
        @(posedge clk); #1;
        req_valid[port] = 1'b0;
        ok = 0;
        lat_rsp = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            lat_rsp++;
            if (rr_rsp_valid[port]) ok = 1;
        end
        if (!ok) timeout_fail("rsp_valid wait");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lr, lp;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset.req_ready", 32'(rr_req_ready), 32'd0);
        check("reset.rsp_valid", 32'(rr_rsp_valid), 32'd0);
        check("reset.rsp_c", rr_rsp_c, 32'd0);
        check("reset.alu_op", 32'(rr_alu_op), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single op on port 0: 5 + 3
        run_op(0, 32'd5, 32'd3, 4'b0000, lr, lp);
        check("p0_add.ready_latency", 32'(lr), 32'd1);
        check("p0_add.rsp_latency", 32'(lp), 32'd2);
        check("p0_add.rsp_valid", 32'(rr_rsp_valid), 32'h1);
        check("p0_add.rsp_c", rr_rsp_c, 32'd8);
        check("p0_add.rsp_ovf", 32'(rr_rsp_ovf), 32'd0);
        check("p0_add.rsp_dis", 32'(rr_rsp_dis), 32'd0);

        // Overflow kept for 1001, masked for 0000
        run_op(1, 32'h7FFF_FFFF, 32'd1, 4'b1001, lr, lp);
        check("ovf1001.rsp_c", rr_rsp_c, 32'h8000_0000);
        check("ovf1001.rsp_ovf", 32'(rr_rsp_ovf), 32'd1);
        run_op(1, 32'h7FFF_FFFF, 32'd1, 4'b0000, lr, lp);
        check("ovf0000.rsp_c", rr_rsp_c, 32'h8000_0000);
        check("ovf0000.rsp_ovf", 32'(rr_rsp_ovf), 32'd0);

        // Response stall blocks port 1
        @(posedge clk); #1 rsp_ready = 2'b00;
        run_op(0, 32'd7, 32'd0, 4'b1011, lr, lp);
        check("stall.rsp_c", rr_rsp_c, 32'd7);
        check("stall.rsp_dis", 32'(rr_rsp_dis), 32'd1);
        @(posedge clk); #1;
        a1 = 32'd10; b1 = 32'd20; op1 = 4'b0000; req_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall.hold_valid", 32'(rr_rsp_valid), 32'h1);
            check("stall.hold_c", rr_rsp_c, 32'd7);
            check("stall.hold_dis", 32'(rr_rsp_dis), 32'd1);
            check("stall.p1_blocked", 32'(rr_req_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 2'b01;
        @(posedge clk); #1 rsp_ready = 2'b11;
        @(negedge clk);
        check("stall.p1_accept_rr", 32'(rr_req_ready), 32'h2);
        check("stall.p1_accept_fp", 32'(fp_req_ready), 32'h2);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("stall.p1_rsp_valid", 32'(rr_rsp_valid), 32'h2);
        check("stall.p1_rsp_c", rr_rsp_c, 32'd30);

        // Contention from reset: 4 ops with both ports valid
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        a0 = 32'd1; b0 = 32'd2; op0 = 4'b0000;
        a1 = 32'd3; b1 = 32'd4; op1 = 4'b0100;
        req_valid = 2'b11;
        repeat (11) @(posedge clk); #1 req_valid = 2'b00;
        repeat (3) @(negedge clk);
        check("rr.grant_count", 32'(glog_n[0]), 32'd4);
        check("fp.grant_count", 32'(glog_n[1]), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr.grant%0d", k), 32'(glog[0][k]), 32'(k % 2));
            check($sformatf("fp.grant%0d", k), 32'(glog[1][k]), 32'd0);
        end

        // Reset during EXEC
        @(posedge clk); #1;
        a1 = 32'd9; b1 = 32'd9; op1 = 4'b0000; req_valid = 2'b10;
        @(negedge clk);
        check("midrst.accept", 32'(rr_req_ready), 32'h2);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("midrst.req_ready", 32'(rr_req_ready), 32'd0);
        check("midrst.rsp_valid", 32'(rr_rsp_valid), 32'd0);
        check("midrst.rsp_c", rr_rsp_c, 32'd0);
        check("midrst.alu_a", rr_alu_a, 32'd0);
        check("midrst.alu_op", 32'(rr_alu_op), 32'd0);
        check("midrst.fp_alu_a", fp_alu_a, 32'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        a0 = 32'd11; b0 = 32'd22; op0 = 4'b0000; req_valid = 2'b11;
        @(negedge clk);
        check("postrst.grant_rr", 32'(rr_req_ready), 32'h1);
        check("postrst.grant_fp", 32'(fp_req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (2) @(negedge clk);
        check("postrst.rsp_valid", 32'(rr_rsp_valid), 32'h1);
        check("postrst.rsp_c", rr_rsp_c, 32'd33);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
